// File: rtl/decode_pkg.sv
// Shared types for the RISC-V decode stage: enums, opcode constants, the decoded
// bundle and immediate extraction helpers.
package decode_pkg;

    typedef enum logic [3:0] {
        ExNop    = 4'd0,
        ExAdd    = 4'd1,
        ExSub    = 4'd2,
        ExSll    = 4'd3,
        ExSlt    = 4'd4,
        ExXor    = 4'd5,
        ExSrl    = 4'd6,
        ExSra    = 4'd7,
        ExOr     = 4'd8,
        ExAnd    = 4'd9,
        ExMul    = 4'd10,
        ExMulh   = 4'd11,
        ExDiv    = 4'd12,
        ExRem    = 4'd13,
        ExBranch = 4'd14,
        ExAuipc  = 4'd15
    } ex_op_t;

    typedef enum logic [2:0] {
        BrEq   = 3'd0,
        BrNe   = 3'd1,
        BrLt   = 3'd2,
        BrGe   = 3'd3,
        BrLtu  = 3'd4,
        BrGeu  = 3'd5,
        BrJal  = 3'd6,
        BrJalr = 3'd7
    } branch_t;

    typedef enum logic [2:0] {
        SizeByte         = 3'd0,
        SizeHalf         = 3'd1,
        SizeWord         = 3'd2,
        SizeDouble       = 3'd3,
        SizeUnsignedWord = 3'd4,
        SizeUnsignedHalf = 3'd5,
        SizeUnsignedByte = 3'd6
    } mem_size_t;

    typedef enum logic [2:0] {
        MemNone      = 3'd0,
        MemLoad      = 3'd1,
        MemStore     = 3'd2,
        MemWriteback = 3'd3,
        MemEcall     = 3'd4
    } mem_op_t;

    localparam logic [6:0] OpcOpImm   = 7'h13;
    localparam logic [6:0] OpcOpImm32 = 7'h1b;
    localparam logic [6:0] OpcOp      = 7'h33;
    localparam logic [6:0] OpcOp32    = 7'h3b;
    localparam logic [6:0] OpcLui     = 7'h37;
    localparam logic [6:0] OpcAuipc   = 7'h17;
    localparam logic [6:0] OpcJal     = 7'h6f;
    localparam logic [6:0] OpcJalr    = 7'h67;
    localparam logic [6:0] OpcBranch  = 7'h63;
    localparam logic [6:0] OpcLoad    = 7'h03;
    localparam logic [6:0] OpcStore   = 7'h23;
    localparam logic [6:0] OpcSystem  = 7'h73;

    localparam logic [1:0] UnsUnsigned = 2'd1;
    localparam logic [1:0] UnsMixed    = 2'd2;

    // imm is always carried at 64 bits; the top truncates to XLEN.
    typedef struct packed {
        ex_op_t     ex_opcode;
        branch_t    branch_type;
        logic [4:0] r1_reg;
        logic [4:0] r2_reg;
        logic [4:0] dst_reg;
        logic [63:0] imm;
        logic       is_word_op;
        logic [1:0] unsigned_op;
        logic       imm_or_reg2;
        mem_op_t    mem_opcode;
        mem_size_t  mem_operation_size;
        logic       ecall;
        logic       illegal;
    } decoded_t;

    function automatic logic [63:0] imm_i(input logic [31:0] i);
        return {{52{i[31]}}, i[31:20]};
    endfunction

    function automatic logic [63:0] imm_s(input logic [31:0] i);
        return {{52{i[31]}}, i[31:25], i[11:7]};
    endfunction

    function automatic logic [63:0] imm_b(input logic [31:0] i);
        return {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    endfunction

    function automatic logic [63:0] imm_u(input logic [31:0] i);
        return {{32{i[31]}}, i[31:12], 12'd0};
    endfunction

    function automatic logic [63:0] imm_j(input logic [31:0] i);
        return {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/decode_fields.sv
// Combinational RISC-V instruction decoder producing the execute/memory control
// bundle; disabled or unknown encodings collapse to an all-zero bundle with illegal set.
module decode_fields
    import decode_pkg::*;
#(
    parameter int unsigned XLEN  = 64,
    parameter bit          HAS_M = 1'b1
) (
    input  logic [31:0] instruction,
    output decoded_t    decoded
);

    localparam bit Rv32 = (XLEN == 32);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       word;
    logic       bad;

    assign opcode = instruction[6:0];
    assign rd     = instruction[11:7];
    assign funct3 = instruction[14:12];
    assign rs1    = instruction[19:15];
    assign rs2    = instruction[24:20];
    assign funct7 = instruction[31:25];
    assign word   = (opcode == OpcOpImm32) || (opcode == OpcOp32);

    always_comb begin
        decoded = '0;
        bad     = 1'b0;
        case (opcode)
            OpcOpImm, OpcOpImm32: begin
                decoded.r1_reg      = rs1;
                decoded.dst_reg     = rd;
                decoded.imm         = imm_i(instruction);
                decoded.imm_or_reg2 = 1'b1;
                decoded.is_word_op  = word;
                decoded.mem_opcode  = MemWriteback;
                case (funct3)
                    3'd0: decoded.ex_opcode = ExAdd;
                    3'd1, 3'd5: begin
                        decoded.imm       = {58'd0, instruction[25:20]};
                        decoded.ex_opcode = (funct3 == 3'd1) ? ExSll :
                                            (instruction[30] ? ExSra : ExSrl);
                        // Bit 30 selects SRAI; bit 25 is shamt[5], only valid on RV64 non-word.
                        if (instruction[31] || instruction[29:26] != 4'd0 ||
                            (instruction[30] && funct3 == 3'd1)) bad = 1'b1;
                        if (instruction[25] && (word || Rv32)) bad = 1'b1;
                    end
                    3'd2: decoded.ex_opcode = ExSlt;
                    3'd3: begin
                        decoded.ex_opcode   = ExSlt;
                        decoded.unsigned_op = UnsUnsigned;
                    end
                    3'd4: decoded.ex_opcode = ExXor;
                    3'd6: decoded.ex_opcode = ExOr;
                    default: decoded.ex_opcode = ExAnd;
                endcase
                if (word && !(funct3 inside {3'd0, 3'd1, 3'd5})) bad = 1'b1;
                if (word && Rv32) bad = 1'b1;
            end
            OpcOp, OpcOp32: begin
                decoded.r1_reg     = rs1;
                decoded.r2_reg     = rs2;
                decoded.dst_reg    = rd;
                decoded.is_word_op = word;
                decoded.mem_opcode = MemWriteback;
                case (funct7)
                    7'h00: begin
                        case (funct3)
                            3'd0: decoded.ex_opcode = ExAdd;
                            3'd1: decoded.ex_opcode = ExSll;
                            3'd2: decoded.ex_opcode = ExSlt;
                            3'd3: begin
                                decoded.ex_opcode   = ExSlt;
                                decoded.unsigned_op = UnsUnsigned;
                            end
                            3'd4: decoded.ex_opcode = ExXor;
                            3'd5: decoded.ex_opcode = ExSrl;
                            3'd6: decoded.ex_opcode = ExOr;
                            default: decoded.ex_opcode = ExAnd;
                        endcase
                        if (word && !(funct3 inside {3'd0, 3'd1, 3'd5})) bad = 1'b1;
                    end
                    7'h20: begin
                        if (funct3 == 3'd0) decoded.ex_opcode = ExSub;
                        else if (funct3 == 3'd5) decoded.ex_opcode = ExSra;
                        else bad = 1'b1;
                    end
                    7'h01: begin
                        case (funct3)
                            3'd0: decoded.ex_opcode = ExMul;
                            3'd1: decoded.ex_opcode = ExMulh;
                            3'd2: begin
                                decoded.ex_opcode   = ExMulh;
                                decoded.unsigned_op = UnsMixed;
                            end
                            3'd3: begin
                                decoded.ex_opcode   = ExMulh;
                                decoded.unsigned_op = UnsUnsigned;
                            end
                            3'd4: decoded.ex_opcode = ExDiv;
                            3'd5: begin
                                decoded.ex_opcode   = ExDiv;
                                decoded.unsigned_op = UnsUnsigned;
                            end
                            3'd6: decoded.ex_opcode = ExRem;
                            default: begin
                                decoded.ex_opcode   = ExRem;
                                decoded.unsigned_op = UnsUnsigned;
                            end
                        endcase
                        if (!HAS_M || (word && funct3 inside {3'd1, 3'd2, 3'd3})) bad = 1'b1;
                    end
                    default: bad = 1'b1;
                endcase
                if (word && Rv32) bad = 1'b1;
            end
            OpcLui, OpcAuipc: begin
                decoded.dst_reg     = rd;
                decoded.imm         = imm_u(instruction);
                decoded.imm_or_reg2 = 1'b1;
                decoded.mem_opcode  = MemWriteback;
                decoded.ex_opcode   = (opcode == OpcLui) ? ExAdd : ExAuipc;
            end
            OpcJal: begin
                decoded.dst_reg     = rd;
                decoded.imm         = imm_j(instruction);
                decoded.imm_or_reg2 = 1'b1;
                decoded.mem_opcode  = MemWriteback;
                decoded.ex_opcode   = ExBranch;
                decoded.branch_type = BrJal;
            end
            OpcJalr: begin
                decoded.r1_reg      = rs1;
                decoded.dst_reg     = rd;
                decoded.imm         = imm_i(instruction);
                decoded.imm_or_reg2 = 1'b1;
                decoded.mem_opcode  = MemWriteback;
                decoded.ex_opcode   = ExBranch;
                decoded.branch_type = BrJalr;
                if (funct3 != 3'd0) bad = 1'b1;
            end
            OpcBranch: begin
                decoded.r1_reg    = rs1;
                decoded.r2_reg    = rs2;
                decoded.imm       = imm_b(instruction);
                decoded.ex_opcode = ExBranch;
                case (funct3)
                    3'd0: decoded.branch_type = BrEq;
                    3'd1: decoded.branch_type = BrNe;
                    3'd4: decoded.branch_type = BrLt;
                    3'd5: decoded.branch_type = BrGe;
                    3'd6: begin
                        decoded.branch_type = BrLtu;
                        decoded.unsigned_op = UnsUnsigned;
                    end
                    3'd7: begin
                        decoded.branch_type = BrGeu;
                        decoded.unsigned_op = UnsUnsigned;
                    end
                    default: bad = 1'b1;
                endcase
            end
            OpcLoad: begin
                decoded.r1_reg      = rs1;
                decoded.dst_reg     = rd;
                decoded.imm         = imm_i(instruction);
                decoded.imm_or_reg2 = 1'b1;
                decoded.ex_opcode   = ExAdd;
                decoded.mem_opcode  = MemLoad;
                case (funct3)
                    3'd0: decoded.mem_operation_size = SizeByte;
                    3'd1: decoded.mem_operation_size = SizeHalf;
                    3'd2: decoded.mem_operation_size = SizeWord;
                    3'd3: begin
                        decoded.mem_operation_size = SizeDouble;
                        if (Rv32) bad = 1'b1;
                    end
                    3'd4: decoded.mem_operation_size = SizeUnsignedByte;
                    3'd5: decoded.mem_operation_size = SizeUnsignedHalf;
                    3'd6: begin
                        decoded.mem_operation_size = SizeUnsignedWord;
                        if (Rv32) bad = 1'b1;
                    end
                    default: bad = 1'b1;
                endcase
            end
            OpcStore: begin
                decoded.r1_reg      = rs1;
                decoded.r2_reg      = rs2;
                decoded.imm         = imm_s(instruction);
                decoded.imm_or_reg2 = 1'b1;
                decoded.ex_opcode   = ExAdd;
                decoded.mem_opcode  = MemStore;
                case (funct3)
                    3'd0: decoded.mem_operation_size = SizeByte;
                    3'd1: decoded.mem_operation_size = SizeHalf;
                    3'd2: decoded.mem_operation_size = SizeWord;
                    3'd3: begin
                        decoded.mem_operation_size = SizeDouble;
                        if (Rv32) bad = 1'b1;
                    end
                    default: bad = 1'b1;
                endcase
            end
            OpcSystem: begin
                // ECALL and EBREAK only; CSR accesses are not supported here.
                if (funct3 == 3'd0 && rs1 == 5'd0 && rd == 5'd0 &&
                    instruction[31:21] == 11'd0) begin
                    decoded.ecall      = 1'b1;
                    decoded.mem_opcode = MemEcall;
                end else begin
                    bad = 1'b1;
                end
            end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            decoded         = '0;
            decoded.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_decode_buffered.sv
// Registered decode stage with valid/ready handshake, an output register plus one
// skid entry, bubble squashing and synchronous flush.
module pipeline_decode_buffered
    import decode_pkg::*;
#(
    parameter int unsigned XLEN        = 64,
    parameter bit          HAS_M       = 1'b1,
    parameter logic [31:0] BUBBLE_INSN = 32'd90
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] instruction_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [3:0]      ex_opcode,
    output logic [2:0]      branch_type,
    output logic [4:0]      r1_reg,
    output logic [4:0]      r2_reg,
    output logic [4:0]      dst_reg,
    output logic [XLEN-1:0] imm,
    output logic            is_word_op,
    output logic [1:0]      unsigned_op,
    output logic            imm_or_reg2,
    output logic [2:0]      mem_opcode,
    output logic [2:0]      mem_operation_size,
    output logic            ecall,
    output logic            illegal
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        decoded_t        dec;
    } entry_t;

    decoded_t in_dec;
    entry_t   in_entry;
    entry_t   out_q, out_d;
    entry_t   skid_q, skid_d;
    logic     out_valid_q, out_valid_d;
    logic     skid_valid_q, skid_valid_d;
    logic     write;
    logic     out_free;

    decode_fields #(
        .XLEN  (XLEN),
        .HAS_M (HAS_M)
    ) u_fields (
        .instruction (instruction),
        .decoded     (in_dec)
    );

    assign in_entry = {instruction_pc, in_dec};
    assign in_ready = !skid_valid_q;
    // A bubble still completes the handshake but never occupies an entry.
    assign write    = in_valid && in_ready && (instruction != BUBBLE_INSN);
    assign out_free = !out_valid_q || out_ready;

    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = write;
                if (write) out_d = in_entry;
            end
        end else if (write) begin
            skid_d       = in_entry;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_valid          = out_valid_q;
    assign out_pc             = out_q.pc;
    assign ex_opcode          = out_q.dec.ex_opcode;
    assign branch_type        = out_q.dec.branch_type;
    assign r1_reg             = out_q.dec.r1_reg;
    assign r2_reg             = out_q.dec.r2_reg;
    assign dst_reg            = out_q.dec.dst_reg;
    assign imm                = out_q.dec.imm[XLEN-1:0];
    assign is_word_op         = out_q.dec.is_word_op;
    assign unsigned_op        = out_q.dec.unsigned_op;
    assign imm_or_reg2        = out_q.dec.imm_or_reg2;
    assign mem_opcode         = out_q.dec.mem_opcode;
    assign mem_operation_size = out_q.dec.mem_operation_size;
    assign ecall              = out_q.dec.ecall;
    assign illegal            = out_q.dec.illegal;

endmodule

// File: tb/tb_pipeline_decode_buffered.sv
// Directed bench: an RV64+M instance and an RV32-without-M instance share stimulus.
module tb_pipeline_decode_buffered;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] instruction;
    logic [63:0] instruction_pc;

    logic        a_in_ready, a_out_valid, a_word, a_ior, a_ecall, a_illegal;
    logic [63:0] a_out_pc, a_imm;
    logic [3:0]  a_ex;
    logic [2:0]  a_br, a_mem, a_size;
    logic [4:0]  a_r1, a_r2, a_dst;
    logic [1:0]  a_uns;

    logic        b_in_ready, b_out_valid, b_word, b_ior, b_ecall, b_illegal;
    logic [31:0] b_out_pc, b_imm;
    logic [3:0]  b_ex;
    logic [2:0]  b_br, b_mem, b_size;
    logic [4:0]  b_r1, b_r2, b_dst;
    logic [1:0]  b_uns;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipeline_decode_buffered #(.XLEN(64), .HAS_M(1'b1), .BUBBLE_INSN(32'd90)) dut (
        .clk (clk), .reset (reset), .flush (flush),
        .in_valid (in_valid), .in_ready (a_in_ready),
        .instruction (instruction), .instruction_pc (instruction_pc),
        .out_valid (a_out_valid), .out_ready (out_ready), .out_pc (a_out_pc),
        .ex_opcode (a_ex), .branch_type (a_br),
        .r1_reg (a_r1), .r2_reg (a_r2), .dst_reg (a_dst), .imm (a_imm),
        .is_word_op (a_word), .unsigned_op (a_uns), .imm_or_reg2 (a_ior),
        .mem_opcode (a_mem), .mem_operation_size (a_size),
        .ecall (a_ecall), .illegal (a_illegal)
    );

    pipeline_decode_buffered #(.XLEN(32), .HAS_M(1'b0), .BUBBLE_INSN(32'd90)) dut32 (
        .clk (clk), .reset (reset), .flush (flush),
        .in_valid (in_valid), .in_ready (b_in_ready),
        .instruction (instruction), .instruction_pc (instruction_pc[31:0]),
        .out_valid (b_out_valid), .out_ready (out_ready), .out_pc (b_out_pc),
        .ex_opcode (b_ex), .branch_type (b_br),
        .r1_reg (b_r1), .r2_reg (b_r2), .dst_reg (b_dst), .imm (b_imm),
        .is_word_op (b_word), .unsigned_op (b_uns), .imm_or_reg2 (b_ior),
        .mem_opcode (b_mem), .mem_operation_size (b_size),
        .ecall (b_ecall), .illegal (b_illegal)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] insn, input logic [63:0] pc);
        in_valid       = v;
        instruction    = insn;
        instruction_pc = pc;
    endtask

    localparam logic [31:0] InsA = 32'h00100513; // addi x10,x0,1
    localparam logic [31:0] InsB = 32'h00200593; // addi x11,x0,2
    localparam logic [31:0] InsC = 32'h00300613; // addi x12,x0,3
    localparam logic [31:0] InsD = 32'h00400693; // addi x13,x0,4

    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, 32'd0, 64'd0);
        step();
        step();
        check("rst_a_valid", 64'(a_out_valid), 64'(0));
        check("rst_a_ready", 64'(a_in_ready), 64'(1));
        check("rst_a_bundle", 64'(|{a_out_pc, a_ex, a_br, a_r1, a_r2, a_dst, a_imm, a_word,
                                     a_uns, a_ior, a_mem, a_size, a_ecall, a_illegal}), 64'(0));
        check("rst_b_bundle", 64'(|{b_out_valid, b_out_pc, b_ex, b_br, b_r1, b_r2, b_dst, b_imm,
                                     b_word, b_uns, b_ior, b_mem, b_size, b_ecall, b_illegal}),
              64'(0));
        check("rst_b_ready", 64'(b_in_ready), 64'(1));
        reset = 1'b0;

        // ADDI x5,x1,-1
        drive(1'b1, 32'hFFF08293, 64'h100);
        step();
        check("addi_valid", 64'(a_out_valid), 64'(1));
        check("addi_ops", 64'({a_ex, a_r1, a_r2, a_dst}), 64'({4'd1, 5'd1, 5'd0, 5'd5}));
        check("addi_imm", a_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        check("addi_mem", 64'({a_mem, a_ior, a_illegal}), 64'({3'd3, 1'b1, 1'b0}));
        check("addi_pc", a_out_pc, 64'h100);
        check("addi_imm32", 64'(b_imm), 64'hFFFF_FFFF);

        // MUL x3,x1,x2
        drive(1'b1, 32'h022081B3, 64'h104);
        step();
        check("mul_ops", 64'({a_ex, a_r1, a_r2, a_dst, a_illegal}),
              64'({4'd10, 5'd1, 5'd2, 5'd3, 1'b0}));
        check("mul_nom_illegal", 64'({b_out_valid, b_illegal}), 64'({1'b1, 1'b1}));
        check("mul_nom_zero", 64'({b_ex, b_r1, b_r2, b_dst, b_mem}), 64'(0));
        check("mul_nom_pc", 64'(b_out_pc), 64'h104);

        // ADDIW x1,x1,1
        drive(1'b1, 32'h0010809B, 64'h108);
        step();
        check("addiw_ops", 64'({a_ex, a_word, a_dst, a_r1, a_illegal}),
              64'({4'd1, 1'b1, 5'd1, 5'd1, 1'b0}));
        check("addiw_imm", a_imm, 64'd1);
        check("addiw_rv32", 64'({b_illegal, b_ex, b_word}), 64'({1'b1, 4'd0, 1'b0}));

        // BNE x1,x2,+8
        drive(1'b1, 32'h00209463, 64'h10C);
        step();
        check("bne_ops", 64'({a_ex, a_br, a_r1, a_r2, a_dst}),
              64'({4'd14, 3'd1, 5'd1, 5'd2, 5'd0}));
        check("bne_imm", a_imm, 64'd8);
        check("bne_mem", 64'({a_mem, a_ior}), 64'({3'd0, 1'b0}));

        // LW x6,-4(x2)
        drive(1'b1, 32'hFFC12303, 64'h110);
        step();
        check("lw_ops", 64'({a_mem, a_size, a_dst, a_r1, a_ior}),
              64'({3'd1, 3'd2, 5'd6, 5'd2, 1'b1}));
        check("lw_imm", a_imm, 64'hFFFF_FFFF_FFFF_FFFC);

        drive(1'b1, 32'h00000073, 64'h114);
        step();
        check("ecall", 64'({a_ecall, a_mem, a_ex, a_illegal}), 64'({1'b1, 3'd4, 4'd0, 1'b0}));

        drive(1'b1, 32'h0000007F, 64'h118);
        step();
        check("bad_opc", 64'({a_out_valid, a_illegal, a_ex, a_mem}),
              64'({1'b1, 1'b1, 4'd0, 3'd0}));
        check("bad_opc_pc", a_out_pc, 64'h118);

        drive(1'b0, 32'd0, 64'd0);
        step();
        check("idle_valid", 64'(a_out_valid), 64'(0));

        // Back-pressure stream
        drive(1'b1, InsA, 64'h200);
        step();
        check("st1_pc", a_out_pc, 64'h200);
        check("st1_ready", 64'(a_in_ready), 64'(1));
        out_ready = 1'b0;
        drive(1'b1, InsB, 64'h204);
        step();
        check("st2_hold", 64'({a_out_valid, a_out_pc}), 64'({1'b1, 64'h200}));
        check("st2_ready", 64'(a_in_ready), 64'(0));
        drive(1'b1, InsC, 64'h208);
        step();
        check("st3_hold", 64'({a_dst, a_out_pc}), 64'({5'd10, 64'h200}));
        check("st3_ready", 64'(a_in_ready), 64'(0));
        out_ready = 1'b1;
        step();
        check("st4_pc", a_out_pc, 64'h204);
        check("st4_ready", 64'(a_in_ready), 64'(1));
        step();
        check("st5_pc", a_out_pc, 64'h208);
        drive(1'b1, InsD, 64'h20C);
        step();
        check("st6_pc", 64'({a_dst, a_out_pc}), 64'({5'd13, 64'h20C}));
        drive(1'b0, 32'd0, 64'd0);
        step();
        check("st7_empty", 64'(a_out_valid), 64'(0));

        // Flush with output and skid full
        out_ready = 1'b0;
        drive(1'b1, InsA, 64'h300);
        step();
        drive(1'b1, InsB, 64'h304);
        step();
        check("fl_full", 64'({a_out_valid, a_in_ready}), 64'({1'b1, 1'b0}));
        flush = 1'b1;
        drive(1'b1, InsC, 64'h308);
        step();
        check("fl_cleared", 64'({a_out_valid, a_in_ready}), 64'({1'b0, 1'b1}));
        drive(1'b1, InsD, 64'h30C);
        step();
        check("fl_drop_accept", 64'({a_out_valid, a_in_ready}), 64'({1'b0, 1'b1}));
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 32'd0, 64'd0);
        step();
        check("fl_no_ghost", 64'(a_out_valid), 64'(0));
        drive(1'b1, InsA, 64'h310);
        step();
        check("fl_resume", 64'({a_out_valid, a_out_pc}), 64'({1'b1, 64'h310}));

        // Bubble between two instructions
        drive(1'b1, InsA, 64'h400);
        step();
        check("bub_first", a_out_pc, 64'h400);
        drive(1'b1, 32'd90, 64'h404);
        step();
        check("bub_none", 64'({a_out_valid, a_in_ready}), 64'({1'b0, 1'b1}));
        drive(1'b1, InsB, 64'h408);
        step();
        check("bub_second", 64'({a_out_valid, a_out_pc}), 64'({1'b1, 64'h408}));
        drive(1'b0, 32'd0, 64'd0);
        step();
        check("bub_end", 64'(a_out_valid), 64'(0));

        // Bubble while stalled must not fill the skid
        drive(1'b1, InsA, 64'h500);
        step();
        out_ready = 1'b0;
        drive(1'b1, 32'd90, 64'h504);
        step();
        check("bub_stall", 64'({a_in_ready, a_out_valid, a_out_pc}),
              64'({1'b1, 1'b1, 64'h500}));

        // Asynchronous reset mid-stall
        drive(1'b1, InsB, 64'h508);
        step();
        check("rs_skid_full", 64'(a_in_ready), 64'(0));
        drive(1'b0, 32'd0, 64'd0);
        #2;
        reset = 1'b1;
        #1;
        check("rs_async", 64'({a_out_valid, a_in_ready, b_out_valid}),
              64'({1'b0, 1'b1, 1'b0}));
        step();
        reset = 1'b0;
        out_ready = 1'b1;
        step();
        check("rs_after", 64'(a_out_valid), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
